// File: rtl/fb_pkg.sv
// Shared constants, parser states and address helper for the framebuffer writer.
package fb_pkg;

    localparam int FB_BYTES  = 9600;
    localparam int FB_ADDR_W = 14;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [FB_ADDR_W-1:0] FB_LIM  = FB_ADDR_W'(FB_BYTES);
    localparam logic [FB_ADDR_W-1:0] FB_LAST = FB_ADDR_W'(FB_BYTES - 1);
    localparam logic [15:0]          LEN_LIM = 16'(FB_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN_HI,
        LEN_LO,
        DATA
    } fb_state_t;

    // Explicit wrap at the last framebuffer byte; 14 bits would not overflow here.
    function automatic logic [FB_ADDR_W-1:0] fb_next_addr(
        input logic [FB_ADDR_W-1:0] a
    );
        return (a == FB_LAST) ? '0 : a + 1'b1;
    endfunction

endpackage

// File: rtl/fb_rx_timeout.sv
// Restartable idle counter; pulses expired after TIMEOUT_CYCLES quiet clocks.
module fb_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic restart,
    output logic expired
);

    localparam int CNT_W =
        (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign expired = run && !restart && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!run || restart || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fb_serial_writer.sv
// UART packet parser writing bytes into the 320x240 mono framebuffer.
// Optional mid-packet idle abort: FB_SERIAL_WRITER_TIMEOUT_EN.
module fb_serial_writer
  import fb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [FB_ADDR_W-1:0] wr_addr,
  output logic [7:0]           wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 pkt_done,
  output logic                 pkt_error
);

  fb_state_t            state;
  logic [5:0]           addr_hi_q;
  logic [7:0]           addr_lo_q;
  logic [7:0]           len_hi_q;
  logic [FB_ADDR_W-1:0] cur_addr;
  logic [FB_ADDR_W-1:0] remaining;

  logic [FB_ADDR_W-1:0] start_addr;
  logic [15:0]          len_req;
  logic                 hdr_bad;
  logic                 expired;

  assign start_addr = {addr_hi_q, addr_lo_q};
  assign len_req    = {len_hi_q, rx_data};
  assign hdr_bad    = (start_addr >= FB_LIM)
                   || (len_req > LEN_LIM);

`ifdef FB_SERIAL_WRITER_TIMEOUT_EN
  fb_rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state != IDLE),
    .restart (rx_valid),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      len_hi_q  <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_error <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_error <= 1'b0;
      if (expired) begin
        state     <= IDLE;
        busy      <= 1'b0;
        pkt_error <= 1'b1;
      end else if (rx_valid) begin
        unique case (state)
          IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state <= ADDR_HI;
              busy  <= 1'b1;
            end
          end
          ADDR_HI: begin
            addr_hi_q <= rx_data[5:0];
            state     <= ADDR_LO;
          end
          ADDR_LO: begin
            addr_lo_q <= rx_data;
            state     <= LEN_HI;
          end
          LEN_HI: begin
            len_hi_q <= rx_data;
            state    <= LEN_LO;
          end
          LEN_LO: begin
            if (hdr_bad) begin
              pkt_error <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cur_addr  <= start_addr;
              remaining <= (len_req == 16'd0) ?
                           FB_LIM :
                           len_req[FB_ADDR_W-1:0];
              state     <= DATA;
            end
          end
          DATA: begin
            wr_en     <= 1'b1;
            wr_addr   <= cur_addr;
            wr_data   <= rx_data;
            cur_addr  <= fb_next_addr(cur_addr);
            remaining <= remaining - 1'b1;
            if (remaining == FB_ADDR_W'(1)) begin
              pkt_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fb_serial_writer.sv
// Scoreboard bench for fb_serial_writer.
// Driver queues expectations; negedge monitor compares.
module tb_fb_serial_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        pkt_done;
  logic        pkt_error;

  typedef struct {
    bit          err;
    logic [13:0] addr;
    logic [7:0]  data;
    bit          done;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   last_cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fb_serial_writer #(.TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .pkt_error (pkt_error)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    last_cyc = cyc;
    rx_valid = 1'b0;
  endtask

  task automatic exp_wr(input logic [13:0] a,
                        input logic [7:0] d,
                        input bit done);
    q.push_back('{1'b0, a, d, done, last_cyc});
  endtask

  task automatic exp_err(input int delay);
    q.push_back('{1'b1, 14'd0, 8'd0, 1'b0,
                  last_cyc + delay});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 &&
        (wr_en || pkt_done || pkt_error)) begin
      if (q.size() == 0) begin
        chk("unexpected_output",
            {wr_en, pkt_done, pkt_error}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pkt_error", pkt_error, e.err);
        chk("wr_en", wr_en, !e.err);
        chk("cycle", cyc, e.cyc);
        if (!e.err) begin
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("pkt_done", pkt_done, e.done);
        end
        if (e.err || e.done) chk("busy_fall", busy, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_error", pkt_error, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    send(8'hA5);
    chk("busy_rise", busy, 1);
    send(8'h00); send(8'h00); send(8'h00); send(8'h03);
    send(8'h11); exp_wr(14'd0, 8'h11, 0);
    send(8'h22); exp_wr(14'd1, 8'h22, 0);
    send(8'h33); exp_wr(14'd2, 8'h33, 1);
    idle(2);

    send(8'hA5); send(8'h25); send(8'h7E);
    send(8'h00); send(8'h04);
    send(8'hAA); exp_wr(14'd9598, 8'hAA, 0);
    send(8'hBB); exp_wr(14'd9599, 8'hBB, 0);
    send(8'hCC); exp_wr(14'd0, 8'hCC, 0);
    send(8'hDD); exp_wr(14'd1, 8'hDD, 1);
    idle(2);

    send(8'hA5); send(8'h25); send(8'h80);
    send(8'h00); send(8'h01);
    exp_err(0);
    idle(3);

    send(8'hA5); send(8'h00); send(8'h00);
    send(8'h25); send(8'h81);
    exp_err(0);
    idle(3);

    send(8'h00); send(8'hFF);
    chk("garbage_idle", busy, 0);
    send(8'hA5); send(8'hC0); send(8'h03);
    send(8'h00); send(8'h01);
    send(8'h99); exp_wr(14'd3, 8'h99, 1);
    idle(2);

    send(8'hA5); send(8'h00); send(8'h00);
    send(8'h00); send(8'h02);
    send(8'hA5); exp_wr(14'd0, 8'hA5, 0);
    send(8'hA5); exp_wr(14'd1, 8'hA5, 1);
    idle(2);

    send(8'hA5); send(8'h00); send(8'h00);
    send(8'h00); send(8'h00);
    for (int i = 0; i < 9600; i++) begin
      logic [7:0] d;
      d = i[7:0] ^ 8'h5A;
      send(d);
      exp_wr(14'(i), d, i == 9599);
    end
    idle(2);

    send(8'hA5); send(8'h00); send(8'h10);
    send(8'h00); send(8'h05);
    send(8'h11); exp_wr(14'd16, 8'h11, 0);
    send(8'h22); exp_wr(14'd17, 8'h22, 0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_wr_data", wr_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_done", pkt_done, 0);
    chk("mid_rst_error", pkt_error, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    send(8'hA5); send(8'h00); send(8'h05);
    send(8'h00); send(8'h01);
    send(8'h77); exp_wr(14'd5, 8'h77, 1);
    idle(2);

`ifdef FB_SERIAL_WRITER_TIMEOUT_EN
    send(8'hA5); send(8'h00); send(8'h01);
    exp_err(100);
    idle(110);
    chk("timeout_idle", busy, 0);
`endif

    idle(4);
    @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
